// File: rtl/req_arb_pkg.sv
// Shared types and constants for the eight-way request arbiter.
// Imported by pri_enc8 and req_arbiter8.
package req_arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE,
      OWNED
   } arb_state_e;

   localparam logic [ID_W-1:0] ID_IDLE = 3'b000;

endpackage

// File: rtl/pri_enc8.sv
// 8:3 encoder: first set bit scanning upward from a rotate offset.
// Offset 0 on a bit-reversed vector yields highest-index priority.
module pri_enc8
   import req_arb_pkg::*;
(
   input  logic [N_REQ-1:0] vec,
   input  logic [ID_W-1:0]  off,
   output logic [ID_W-1:0]  idx,
   output logic             found
);

   logic [N_REQ-1:0] rot;

   always_comb begin
      rot   = '0;
      idx   = ID_IDLE;
      found = 1'b0;
      for (int j = 0; j < N_REQ; j++)
         rot[j] = vec[ID_W'(j) + off];
      // Descending scan so the lowest rotated position is the last write.
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            idx   = ID_W'(j) + off;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_arbiter8.sv
// Registered eight-way grant arbiter with hold timeout.
// Define REQ_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed.
module req_arbiter8
   import req_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

   arb_state_e       state, state_n;
   logic [N_REQ-1:0] grant_n, onehot, enc_vec;
   logic [ID_W-1:0]  id_n, enc_off, enc_idx, win;
   logic             valid_n, to_n, enc_found;
   logic [CNT_W-1:0] cnt, cnt_n;

`ifdef REQ_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] ptr, ptr_n;

   assign enc_vec = req;
   assign enc_off = ptr + ID_W'(1);
   assign win     = enc_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= ID_IDLE;
      else        ptr <= ptr_n;
   end
`else
   always_comb begin
      enc_vec = '0;
      for (int j = 0; j < N_REQ; j++)
         enc_vec[j] = req[N_REQ-1-j];
   end

   assign enc_off = ID_IDLE;
   assign win     = ~enc_idx;
`endif

   pri_enc8 u_enc (
      .vec   (enc_vec),
      .off   (enc_off),
      .idx   (enc_idx),
      .found (enc_found)
   );

   always_comb begin
      onehot      = '0;
      onehot[win] = 1'b1;
      state_n     = state;
      grant_n     = '0;
      id_n        = ID_IDLE;
      valid_n     = 1'b0;
      to_n        = 1'b0;
      cnt_n       = '0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
      ptr_n       = ptr;
`endif
      case (state)
         IDLE: begin
            if (en && enc_found) begin
               state_n = OWNED;
               grant_n = onehot;
               id_n    = win;
               valid_n = 1'b1;
               cnt_n   = CNT_W'(1);
`ifdef REQ_ARB_ROUND_ROBIN_EN
               ptr_n   = win;
`endif
            end
         end
         OWNED: begin
            if (en && req[gnt_id] && cnt < HOLD_LIM) begin
               grant_n = grant;
               id_n    = gnt_id;
               valid_n = 1'b1;
               cnt_n   = (&cnt) ? cnt : cnt + CNT_W'(1);
            end else begin
               // Release and disable win over an expiring hold.
               state_n = IDLE;
               to_n    = en && req[gnt_id];
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         gnt_id    <= ID_IDLE;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         gnt_id    <= id_n;
         gnt_valid <= valid_n;
         timeout   <= to_n;
         cnt       <= cnt_n;
      end
   end

endmodule
